// File: rtl/fp_round_pkg.sv
// rtl/fp_round_pkg.sv - rounding modes, flag layout and width mapping for fp_round_pipe
package fp_round_pkg;

  typedef enum logic [2:0] {
    RM_RNE = 3'b000,
    RM_RTZ = 3'b001,
    RM_RUP = 3'b010,
    RM_RDN = 3'b011,
    RM_RMM = 3'b100,
    RM_ROD = 3'b101
  } rm_e;

  typedef struct packed {
    logic ovf;
    logic unf;
    logic inx;
  } flags_t;

  // Zero marks an unsupported width so the top can refuse to elaborate.
  function automatic int exp_width(input int fpwid);
    case (fpwid)
      32:      return 8;
      64:      return 11;
      128:     return 15;
      default: return 0;
    endcase
  endfunction

  function automatic int frac_width(input int fpwid);
    case (fpwid)
      32:      return 23;
      64:      return 52;
      128:     return 112;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/fp_round_decide.sv
// rtl/fp_round_decide.sv - combinational round-increment decision from mode, sign and L/G/R/S
module fp_round_decide
  import fp_round_pkg::*;
(
  input  logic [2:0] rm,
  input  logic       sign,
  input  logic       lsb,
  input  logic [2:0] grs,
  input  logic       special,
  output logic       inc,
  output logic       any
);

  logic g;
  logic r;
  logic s;
  logic any_raw;
  logic inc_raw;

  always_comb begin
    g       = grs[2];
    r       = grs[1];
    s       = grs[0];
    any_raw = |grs;
    inc_raw = 1'b0;
    case (rm)
      RM_RMM:         inc_raw = g;
      RM_RUP:         inc_raw = any_raw & ~sign;
      RM_RDN:         inc_raw = any_raw & sign;
      RM_RTZ, RM_ROD: inc_raw = 1'b0;
      default:        inc_raw = (g & (r | s)) | (g & ~r & ~s & lsb);
    endcase
  end

  // Inf/NaN pass through untouched and raise nothing.
  assign inc = inc_raw & ~special;
  assign any = any_raw & ~special;

endmodule

// File: rtl/fp_round_pipe.sv
// rtl/fp_round_pipe.sv - three-stage IEEE rounding pipeline with global-stall valid/ready handshake
module fp_round_pipe
  import fp_round_pkg::*;
#(
  parameter  int FPWID = 128,
  localparam int EXPW  = exp_width(FPWID),
  localparam int FRACW = frac_width(FPWID)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic [2:0]       i_rm,
  input  logic             i_sign,
  input  logic [EXPW-1:0]  i_exp,
  input  logic [FRACW+3:0] i_man,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [FPWID-1:0] o_result,
  output logic [2:0]       o_flags
);

  if (EXPW == 0) begin : g_bad_fpwid
    $error("fp_round_pipe: FPWID must be 32, 64 or 128");
  end

  localparam int SW = EXPW + FRACW + 1;

  logic advance;
  assign advance = ~o_valid | o_ready;
  assign i_ready = advance;

  // S1: capture the beat together with its rounding decision
  logic inc_d;
  logic any_d;
  logic special_d;
  assign special_d = &i_exp;

  fp_round_decide u_decide (
    .rm      (i_rm),
    .sign    (i_sign),
    .lsb     (i_man[3]),
    .grs     (i_man[2:0]),
    .special (special_d),
    .inc     (inc_d),
    .any     (any_d)
  );

  logic            s1_valid;
  logic            s1_sign;
  logic            s1_inc;
  logic            s1_any;
  logic            s1_special;
  logic            s1_rod;
  logic [EXPW-1:0] s1_exp;
  logic [FRACW:0]  s1_sig;

  // S2: one carry chain over {exp, leading, fraction}
  logic [SW-1:0]   sum;
  logic [EXPW-1:0] sum_exp;
  logic [EXPW-1:0] exp_fix;

  assign sum     = {s1_exp, s1_sig} + SW'(s1_inc);
  assign sum_exp = sum[SW-1 -: EXPW];
  // A subnormal that rounds into the leading bit becomes the smallest normal.
  assign exp_fix = (sum_exp == '0 && sum[FRACW]) ? EXPW'(1) : sum_exp;

  logic             s2_valid;
  logic             s2_sign;
  logic             s2_any;
  logic             s2_special;
  logic             s2_rod;
  logic [EXPW-1:0]  s2_exp;
  logic [FRACW-1:0] s2_frac;

  // S3: fraction select and flags
  flags_t           fl;
  logic [FRACW-1:0] frac_sel;

  always_comb begin
    fl.ovf = ~s2_special & (&s2_exp);
    fl.inx = s2_any;
    fl.unf = s2_any & (s2_exp == '0);
    if (fl.ovf) begin
      frac_sel = '0;
    end else begin
      frac_sel = s2_frac | FRACW'(s2_rod & s2_any);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else if (advance) begin
      s1_valid <= i_valid;
      s2_valid <= s1_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      s1_sign    <= i_sign;
      s1_inc     <= inc_d;
      s1_any     <= any_d;
      s1_special <= special_d;
      s1_rod     <= (i_rm == RM_ROD);
      s1_exp     <= i_exp;
      s1_sig     <= i_man[FRACW+3:3];

      s2_sign    <= s1_sign;
      s2_any     <= s1_any;
      s2_special <= s1_special;
      s2_rod     <= s1_rod;
      s2_exp     <= exp_fix;
      s2_frac    <= sum[FRACW-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid  <= 1'b0;
      o_result <= '0;
      o_flags  <= '0;
    end else if (advance) begin
      o_valid  <= s2_valid;
      o_result <= {s2_sign, s2_exp, frac_sel};
      o_flags  <= fl;
    end
  end

endmodule
